// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared types and constants for the polyphonic note player.
//   voice_state_t : per-voice FSM state (IDLE / PLAY)
//   note_t        : layout of one note-table entry at the default widths,
//                   {period, duration}; the RTL slices flat vectors so that
//                   non-default PERSIZE/DURSIZE still work
//   DUR_SHIFT     : duration field counts units of 2**DUR_SHIFT ticks
// ---------------------------------------------------------------------------
package audio_pkg;

    typedef enum logic {
        IDLE,
        PLAY
    } voice_state_t;

    localparam int DUR_SHIFT   = 4;
    localparam int DEF_PERSIZE = 24;
    localparam int DEF_DURSIZE = 8;

    typedef struct packed {
        logic [DEF_PERSIZE-1:0] period;
        logic [DEF_DURSIZE-1:0] duration;
    } note_t;

endpackage

// File: rtl/audio_voice.sv
// ---------------------------------------------------------------------------
// audio_voice
// One square-wave voice: latches a {period, duration} entry on start and
// plays it until duration*16 ticks have elapsed.
// Ports:
//   clk, reset_b : clock and asynchronous active-low reset
//   i_tick       : one-cycle duration tick from the shared divider
//   i_start      : trigger; ignored when the offered entry has duration 0
//   i_note       : {period, duration} entry offered with i_start
//   o_busy       : voice is in PLAY
//   o_wave       : square-wave output level of this voice
// ---------------------------------------------------------------------------
module audio_voice
    import audio_pkg::*;
#(
    parameter int PERSIZE = 24,
    parameter int DURSIZE = 8
) (
    input  logic                       clk,
    input  logic                       reset_b,
    input  logic                       i_tick,
    input  logic                       i_start,
    input  logic [PERSIZE+DURSIZE-1:0] i_note,
    output logic                       o_busy,
    output logic                       o_wave
);

    localparam int DCW = DURSIZE + DUR_SHIFT;

    voice_state_t       r_state;
    logic [PERSIZE-1:0] r_period;
    logic [PERSIZE-1:0] r_pCount;
    logic [DURSIZE-1:0] r_duration;
    logic [DCW-1:0]     r_dCount;
    logic               r_wave;

    logic [PERSIZE-1:0] w_notePeriod;
    logic [DURSIZE-1:0] w_noteDuration;
    logic               w_accept;
    logic [DCW-1:0]     w_lastCount;

    assign w_notePeriod   = i_note[PERSIZE+DURSIZE-1:DURSIZE];
    assign w_noteDuration = i_note[DURSIZE-1:0];
    // A zero-length entry is a null note and must not disturb the voice.
    assign w_accept       = i_start && (w_noteDuration != '0);
    // Last tick index of the note; duration is never 0 while playing.
    assign w_lastCount    = (DCW'(r_duration) << DUR_SHIFT) - DCW'(1);

    // Voice FSM with its period and duration counters. A start always wins,
    // so a retrigger during PLAY restarts the note from scratch. Ending the
    // note wins over a same-cycle half-period toggle, leaving wave at 0.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state    <= IDLE;
            r_period   <= '0;
            r_pCount   <= '0;
            r_duration <= '0;
            r_dCount   <= '0;
            r_wave     <= 1'b0;
        end else if (w_accept) begin
            r_state    <= PLAY;
            r_period   <= w_notePeriod;
            r_duration <= w_noteDuration;
            r_pCount   <= '0;
            r_dCount   <= '0;
            r_wave     <= 1'b0;
        end else if (r_state == PLAY) begin
            if (i_tick && (r_dCount == w_lastCount)) begin
                r_state  <= IDLE;
                r_pCount <= '0;
                r_dCount <= '0;
                r_wave   <= 1'b0;
            end else begin
                if (i_tick) begin
                    r_dCount <= r_dCount + DCW'(1);
                end
                // Period 0 is a rest: wave stays low, only duration runs.
                if (r_period != '0) begin
                    if (r_pCount == r_period) begin
                        r_pCount <= '0;
                        r_wave   <= ~r_wave;
                    end else begin
                        r_pCount <= r_pCount + PERSIZE'(1);
                    end
                end
            end
        end
    end

    assign o_busy = (r_state == PLAY);
    assign o_wave = r_wave;

endmodule

// File: rtl/audio_poly.sv
// ---------------------------------------------------------------------------
// audio_poly
// Polyphonic square-wave note player: NCHAN voices share a runtime-writable
// note table and a duration tick divider; their waves are mixed into a
// single bit by a first-order sigma-delta modulator.
// Ports:
//   clk, reset_b : clock and asynchronous active-low reset
//   trig         : per-voice one-cycle start pulse
//   note_idx     : per-voice table index, voice i uses slice i
//   tbl_we       : note table write enable
//   tbl_addr     : note table write address
//   tbl_data     : write data {period, duration}
//   busy         : per-voice PLAY indication
//   audio_out    : 1-bit sigma-delta audio stream
// ---------------------------------------------------------------------------
module audio_poly
    import audio_pkg::*;
#(
    parameter int NCHAN   = 2,
    parameter int NNOTES  = 16,
    parameter int PERSIZE = 24,
    parameter int DURSIZE = 8,
    parameter int TICKDIV = 25000
) (
    input  logic                            clk,
    input  logic                            reset_b,
    input  logic [NCHAN-1:0]                trig,
    input  logic [NCHAN*$clog2(NNOTES)-1:0] note_idx,
    input  logic                            tbl_we,
    input  logic [$clog2(NNOTES)-1:0]       tbl_addr,
    input  logic [PERSIZE+DURSIZE-1:0]      tbl_data,
    output logic [NCHAN-1:0]                busy,
    output logic                            audio_out
);

    localparam int IDXW  = $clog2(NNOTES);
    localparam int NOTEW = PERSIZE + DURSIZE;
    localparam int TICKW = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;
    localparam int ACCW  = $clog2(2 * NCHAN + 1);

    logic [NOTEW-1:0] r_table [NNOTES];
    logic [TICKW-1:0] r_tickCount;
    logic [ACCW-1:0]  r_acc;
    logic             r_audio;

    logic             w_tick;
    logic [NOTEW-1:0] w_note [NCHAN];
    logic [NCHAN-1:0] w_wave;
    logic [ACCW-1:0]  w_level;
    logic [ACCW-1:0]  w_sum;

    // Note table: synchronous write, combinational read. Reads see the entry
    // before this cycle's write, so a same-cycle trigger gets the old note.
    // Reset deliberately leaves the contents alone.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            r_table[tbl_addr] <= tbl_data;
        end
    end

    // Free-running duration tick divider; not restarted by triggers.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_tickCount <= '0;
        end else if (w_tick) begin
            r_tickCount <= '0;
        end else begin
            r_tickCount <= r_tickCount + TICKW'(1);
        end
    end

    assign w_tick = (r_tickCount == TICKW'(TICKDIV - 1));

    for (genvar g = 0; g < NCHAN; g++) begin : gVoice
        assign w_note[g] = r_table[note_idx[g*IDXW +: IDXW]];

        audio_voice #(
            .PERSIZE (PERSIZE),
            .DURSIZE (DURSIZE)
        ) uVoice (
            .clk     (clk),
            .reset_b (reset_b),
            .i_tick  (w_tick),
            .i_start (trig[g]),
            .i_note  (w_note[g]),
            .o_busy  (busy[g]),
            .o_wave  (w_wave[g])
        );
    end

    // Mixer level: number of voices whose wave is currently high.
    always_comb begin
        w_level = '0;
        for (int i = 0; i < NCHAN; i++) begin
            w_level = w_level + ACCW'(w_wave[i]);
        end
    end

    // acc stays below NCHAN, so acc+level never exceeds 2*NCHAN-1.
    assign w_sum = r_acc + w_level;

    // First-order sigma-delta: emit a 1 whenever the accumulator crosses
    // NCHAN, giving a long-run density of level/NCHAN.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_acc   <= '0;
            r_audio <= 1'b0;
        end else if (w_sum >= ACCW'(NCHAN)) begin
            r_acc   <= w_sum - ACCW'(NCHAN);
            r_audio <= 1'b1;
        end else begin
            r_acc   <= w_sum;
            r_audio <= 1'b0;
        end
    end

    assign audio_out = r_audio;

endmodule

// File: tb/tb_audio_poly.sv
// ---------------------------------------------------------------------------
// tb_audio_poly
// Bench for audio_poly with NCHAN=2, TICKDIV=4. Each driven cycle pushes the
// expected {busy, audio_out} after the coming edge; a monitor pops and
// compares one entry per clock.
// ---------------------------------------------------------------------------
module tb_audio_poly;
    import audio_pkg::*;

    localparam int NCHAN   = 2;
    localparam int NNOTES  = 16;
    localparam int TICKDIV = 4;
    localparam int IDXW    = 4;

    logic        clk = 1'b0;
    logic        reset_b;
    logic [1:0]  trig;
    logic [7:0]  note_idx;
    logic        tbl_we;
    logic [3:0]  tbl_addr;
    logic [31:0] tbl_data;
    logic [1:0]  busy;
    logic        audio_out;

    always #5 clk = ~clk;

    audio_poly #(
        .NCHAN   (NCHAN),
        .NNOTES  (NNOTES),
        .PERSIZE (24),
        .DURSIZE (8),
        .TICKDIV (TICKDIV)
    ) dut (
        .clk       (clk),
        .reset_b   (reset_b),
        .trig      (trig),
        .note_idx  (note_idx),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_data  (tbl_data),
        .busy      (busy),
        .audio_out (audio_out)
    );

    typedef struct packed {
        logic [1:0] busy;
        logic       audio;
    } expect_t;

    expect_t expQ[$];
    int      nChecks = 0;
    int      nErrors = 0;

    // Reference model state: per voice, when the note started, its period,
    // how many ticks remain, and the current wave level.
    note_t   mTable [NNOTES];
    bit      mPlaying [NCHAN];
    int      mStart [NCHAN];
    int      mPeriod [NCHAN];
    int      mTicksLeft [NCHAN];
    bit      mWave [NCHAN];
    int      mTick = 0;
    int      mAcc = 0;
    int      mEdge = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance the model across the coming clock edge using the inputs that
    // are now being driven, and queue the outputs expected after that edge.
    task automatic modelStep();
        expect_t e;
        int      level;
        bit      tick;
        e = '0;
        if (!reset_b) begin
            for (int v = 0; v < NCHAN; v++) begin
                mPlaying[v] = 1'b0;
                mWave[v]    = 1'b0;
            end
            mTick = 0;
            mAcc  = 0;
        end else begin
            tick  = (mTick == TICKDIV - 1);
            level = 0;
            for (int v = 0; v < NCHAN; v++) level += int'(mWave[v]);
            if (mAcc + level >= NCHAN) begin
                mAcc    = mAcc + level - NCHAN;
                e.audio = 1'b1;
            end else begin
                mAcc    = mAcc + level;
                e.audio = 1'b0;
            end
            for (int v = 0; v < NCHAN; v++) begin
                note_t n;
                n = mTable[note_idx[v*IDXW +: IDXW]];
                if (trig[v] && n.duration != 0) begin
                    mPlaying[v]   = 1'b1;
                    mStart[v]     = mEdge;
                    mPeriod[v]    = int'(n.period);
                    mTicksLeft[v] = 16 * int'(n.duration);
                    mWave[v]      = 1'b0;
                end else if (mPlaying[v]) begin
                    if (tick) begin
                        mTicksLeft[v]--;
                        if (mTicksLeft[v] == 0) mPlaying[v] = 1'b0;
                    end
                    if (!mPlaying[v] || mPeriod[v] == 0)
                        mWave[v] = 1'b0;
                    else
                        mWave[v] = (((mEdge - mStart[v]) / (mPeriod[v] + 1)) % 2) == 1;
                end
                e.busy[v] = mPlaying[v];
            end
            if (tbl_we) mTable[tbl_addr] = tbl_data;
            mTick = (mTick + 1) % TICKDIV;
        end
        mEdge++;
        expQ.push_back(e);
    endtask

    // Drive one cycle of inputs; while reset is held the outputs must already
    // be cleared before any clock edge arrives.
    task automatic applyStimulus(input bit rstb, input logic [1:0] tr, input logic [7:0] idx,
                                 input bit we, input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        reset_b  = rstb;
        trig     = tr;
        note_idx = idx;
        tbl_we   = we;
        tbl_addr = addr;
        tbl_data = data;
        modelStep();
        if (!rstb) begin
            #1;
            checkOutput("asyncResetBusy", 32'(busy), 32'd0);
            checkOutput("asyncResetAudio", 32'(audio_out), 32'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 2'b00, 8'($urandom), 1'b0, 4'd0, 32'd0);
    endtask

    task automatic writeNote(input logic [3:0] addr, input int period, input int dur);
        note_t n;
        n.period   = 24'(period);
        n.duration = 8'(dur);
        applyStimulus(1'b1, 2'b00, 8'd0, 1'b1, addr, n);
    endtask

    task automatic fire(input logic [1:0] tr, input logic [3:0] idx0, input logic [3:0] idx1);
        applyStimulus(1'b1, tr, {idx1, idx0}, 1'b0, 4'd0, 32'd0);
    endtask

    // Monitor: one expected entry per clock, sampled just after the edge.
    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("busy", 32'(busy), 32'(e.busy));
                checkOutput("audio", 32'(audio_out), 32'(e.audio));
            end
        end
    end

    initial begin
        note_t collide;
        reset_b  = 1'b0;
        trig     = 2'b00;
        note_idx = 8'd0;
        tbl_we   = 1'b0;
        tbl_addr = 4'd0;
        tbl_data = 32'd0;
        $display("[TB] start");

        // Reset held while both triggers are high, then release.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 2'b11, 8'h33, 1'b0, 4'd0, 32'd0);
        idle(3);

        // Fill the table with null notes, then the entries under test.
        for (int i = 0; i < NNOTES; i++) writeNote(4'(i), i + 1, 0);
        writeNote(4'd3, 5, 1);
        writeNote(4'd4, 0, 2);
        writeNote(4'd5, 7, 0);
        writeNote(4'd2, 3, 1);
        writeNote(4'd6, 4, 1);

        // Single note, then a rest, then a null entry.
        fire(2'b01, 4'd3, 4'd0);
        idle(75);
        fire(2'b01, 4'd4, 4'd0);
        idle(140);
        fire(2'b10, 4'd0, 4'd5);
        idle(5);

        // Retrigger 30 cycles into a note.
        fire(2'b01, 4'd3, 4'd0);
        idle(29);
        fire(2'b01, 4'd3, 4'd0);
        idle(75);

        // Same-cycle write and trigger: old entry plays, then the new one.
        collide.period   = 24'd9;
        collide.duration = 8'd1;
        applyStimulus(1'b1, 2'b10, {4'd2, 4'd0}, 1'b1, 4'd2, collide);
        idle(75);
        fire(2'b10, 4'd0, 4'd2);
        idle(75);

        // Both voices in phase, then a voice on its own.
        fire(2'b11, 4'd6, 4'd6);
        idle(75);
        fire(2'b10, 4'd0, 4'd6);
        idle(40);

        // Reset in the middle of a note.
        fire(2'b01, 4'd3, 4'd0);
        idle(20);
        applyStimulus(1'b0, 2'b00, 8'd0, 1'b0, 4'd0, 32'd0);
        applyStimulus(1'b0, 2'b01, 8'h03, 1'b0, 4'd0, 32'd0);
        idle(5);

        // Random traffic: occasional writes and triggers on both voices.
        for (int c = 0; c < 600; c++) begin
            logic [1:0] tr;
            bit         we;
            note_t      n;
            tr = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            we = ($urandom_range(0, 19) == 0);
            n.period   = 24'($urandom_range(0, 10));
            n.duration = 8'($urandom_range(0, 2));
            applyStimulus(1'b1, tr, 8'($urandom), we, 4'($urandom), n);
        end
        idle(2);

        for (int k = 0; k < 10 && expQ.size() > 0; k++) @(posedge clk);
        #2;
        checkOutput("queueDrain", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
